// File: rtl/hazard_scheduler.sv
`timescale 1ns/1ps
// Pipeline sequencing controller: register scoreboard, in-flight counting,
// ECALL serialisation and post-branch flush window for the decode stage.
module hazard_scheduler #(
  parameter int INFLIGHT_W = 3,
  parameter int FLUSH_LEN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs1_addr,
  input  logic [4:0]            id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [4:0]            id_wb_addr,
  input  logic                  id_rf_wen,
  input  logic                  id_is_ecall,
  input  logic                  mem_busy,
  input  logic                  wb_valid,
  input  logic                  wb_rf_wen,
  input  logic [4:0]            wb_addr,
  input  logic                  wb_is_ecall,
  input  logic                  wb_branch_hazard,
  output logic                  stall_flg,
  output logic                  flush,
  output logic [31:0]           pending,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic [1:0]            state
);

  localparam int CNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           pending_q, pending_d;
  logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic raw, waw, inflight_full, inflight_zero, issue;

  // Hazards look only at registered scoreboard state; a same-cycle
  // writeback does not release its register until the next cycle.
  assign raw = (id_rs1_used & pending_q[id_rs1_addr]) |
               (id_rs2_used & pending_q[id_rs2_addr]);
  assign waw = id_rf_wen & (id_wb_addr != 5'd0) & pending_q[id_wb_addr];

  assign inflight_full = (inflight_q == {INFLIGHT_W{1'b1}});
  assign inflight_zero = (inflight_q == '0);

  assign flush = ~rst & (wb_branch_hazard | (state_q == ST_FLUSH));

  assign stall_flg = ~rst & ~flush & id_valid &
                     (raw | waw | mem_busy | inflight_full |
                      (state_q != ST_RUN) |
                      (id_is_ecall & ~inflight_zero));

  // Handshake: decode offers an instruction with id_valid; it is accepted
  // (issued) in exactly the cycles where stall_flg and flush are both low.
  assign issue = id_valid & ~stall_flg & ~flush;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    inflight_d = inflight_q;
    cnt_d      = cnt_q;

    if (wb_branch_hazard) begin
      state_d    = ST_FLUSH;
      pending_d  = '0;
      inflight_d = '0;
      cnt_d      = CNT_W'(FLUSH_LEN - 1);
    end else begin
      if (wb_valid & wb_rf_wen & (wb_addr != 5'd0))
        pending_d[wb_addr] = 1'b0;
      if (issue & id_rf_wen & (id_wb_addr != 5'd0))
        pending_d[id_wb_addr] = 1'b1;
      pending_d[0] = 1'b0;

      case ({issue, wb_valid})
        2'b10:   if (!inflight_full) inflight_d = inflight_q + INFLIGHT_W'(1);
        2'b01:   if (!inflight_zero) inflight_d = inflight_q - INFLIGHT_W'(1);
        default: inflight_d = inflight_q;
      endcase

      case (state_q)
        ST_RUN: begin
          if (issue & id_is_ecall)
            state_d = ST_SERIAL;
          else if (id_valid & id_is_ecall & ~inflight_zero)
            state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (inflight_zero && (pending_q == '0))
            state_d = ST_RUN;
        end
        ST_SERIAL: begin
          if (wb_valid & wb_is_ecall)
            state_d = ST_RUN;
        end
        ST_FLUSH: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pending_q  <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pending  = pending_q;
  assign inflight = inflight_q;
  assign state    = state_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
`timescale 1ns/1ps
// Directed bench for hazard_scheduler: RAW, x0, mem_busy, flush window,
// ECALL serialisation, counter saturation and asynchronous reset.
module tb_hazard_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rf_wen, id_is_ecall;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_wb_addr, wb_addr;
  logic        mem_busy, wb_valid, wb_rf_wen, wb_is_ecall, wb_branch_hazard;
  logic        stall_flg, flush;
  logic [31:0] pending;
  logic [2:0]  inflight;
  logic [1:0]  state;

  int n_total = 0;
  int n_pass  = 0;

  hazard_scheduler #(.INFLIGHT_W(3), .FLUSH_LEN(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_wb_addr(id_wb_addr), .id_rf_wen(id_rf_wen), .id_is_ecall(id_is_ecall),
    .mem_busy(mem_busy), .wb_valid(wb_valid), .wb_rf_wen(wb_rf_wen),
    .wb_addr(wb_addr), .wb_is_ecall(wb_is_ecall),
    .wb_branch_hazard(wb_branch_hazard),
    .stall_flg(stall_flg), .flush(flush), .pending(pending),
    .inflight(inflight), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic clear_inputs();
    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_rf_wen = 0; id_is_ecall = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_wb_addr = 0;
    mem_busy = 0; wb_valid = 0; wb_rf_wen = 0; wb_addr = 0; wb_is_ecall = 0;
    wb_branch_hazard = 0;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    id_valid = 1; mem_busy = 1; wb_branch_hazard = 1;
    tick(); #1;
    n_total++; if (pending !== 32'h0) $display("FAIL reset_pending got %0h exp 0", pending); else n_pass++;
    n_total++; if (inflight !== 3'd0) $display("FAIL reset_inflight got %0d exp 0", inflight); else n_pass++;
    n_total++; if (state !== 2'd0) $display("FAIL reset_state got %0d exp 0", state); else n_pass++;
    n_total++; if (stall_flg !== 1'b0) $display("FAIL reset_stall got %0b exp 0", stall_flg); else n_pass++;
    n_total++; if (flush !== 1'b0) $display("FAIL reset_flush got %0b exp 0", flush); else n_pass++;
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_raw();
    tick();
    id_valid = 1; id_rf_wen = 1; id_wb_addr = 5'd5; #1;
    n_total++; if (stall_flg !== 1'b0) $display("FAIL raw_first_issue got %0b exp 0", stall_flg); else n_pass++;
    tick();
    id_rf_wen = 0; id_wb_addr = 0; id_rs1_used = 1; id_rs1_addr = 5'd5; #1;
    n_total++; if (pending !== 32'h20) $display("FAIL raw_pending_set got %0h exp 20", pending); else n_pass++;
    n_total++; if (inflight !== 3'd1) $display("FAIL raw_inflight got %0d exp 1", inflight); else n_pass++;
    n_total++; if (stall_flg !== 1'b1) $display("FAIL raw_stall got %0b exp 1", stall_flg); else n_pass++;
    tick();
    wb_valid = 1; wb_rf_wen = 1; wb_addr = 5'd5; #1;
    n_total++; if (stall_flg !== 1'b1) $display("FAIL raw_no_bypass got %0b exp 1", stall_flg); else n_pass++;
    tick();
    wb_valid = 0; wb_rf_wen = 0; wb_addr = 0; #1;
    n_total++; if (pending !== 32'h0) $display("FAIL raw_pending_clr got %0h exp 0", pending); else n_pass++;
    n_total++; if (stall_flg !== 1'b0) $display("FAIL raw_release got %0b exp 0", stall_flg); else n_pass++;
    tick();
    clear_inputs(); wb_valid = 1; #1;
    n_total++; if (inflight !== 3'd1) $display("FAIL raw_dep_issued got %0d exp 1", inflight); else n_pass++;
    tick();
    clear_inputs(); #1;
    n_total++; if (inflight !== 3'd0) $display("FAIL raw_drained got %0d exp 0", inflight); else n_pass++;
  endtask

  task automatic test_x0();
    id_valid = 1; id_rf_wen = 1; id_wb_addr = 5'd0;
    tick();
    id_rf_wen = 0; id_rs1_used = 1; id_rs1_addr = 5'd0; #1;
    n_total++; if (pending !== 32'h0) $display("FAIL x0_pending got %0h exp 0", pending); else n_pass++;
    n_total++; if (stall_flg !== 1'b0) $display("FAIL x0_stall got %0b exp 0", stall_flg); else n_pass++;
    tick();
    clear_inputs(); wb_valid = 1; #1;
    n_total++; if (inflight !== 3'd2) $display("FAIL x0_inflight got %0d exp 2", inflight); else n_pass++;
    tick(); tick();
    clear_inputs(); #1;
    n_total++; if (inflight !== 3'd0) $display("FAIL x0_drained got %0d exp 0", inflight); else n_pass++;
  endtask

  task automatic test_mem_busy();
    int stalls = 0;
    id_valid = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall_flg === 1'b1) stalls++;
      tick();
    end
    mem_busy = 0; #1;
    n_total++; if (stalls !== 3) $display("FAIL busy_stall_cycles got %0d exp 3", stalls); else n_pass++;
    n_total++; if (stall_flg !== 1'b0) $display("FAIL busy_release got %0b exp 0", stall_flg); else n_pass++;
    n_total++; if (pending !== 32'h0 || inflight !== 3'd0) $display("FAIL busy_state_kept got %0h/%0d exp 0/0", pending, inflight); else n_pass++;
    tick();
    clear_inputs(); wb_valid = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_flush();
    int flush_cycles = 0;
    int stall_seen = 0;
    id_valid = 1; id_rf_wen = 1; id_wb_addr = 5'd5;
    tick();
    id_wb_addr = 5'd6;
    tick();
    clear_inputs(); #1;
    n_total++; if (pending !== 32'h60 || inflight !== 3'd2) $display("FAIL flush_setup got %0h/%0d exp 60/2", pending, inflight); else n_pass++;
    id_valid = 1; id_rs1_used = 1; id_rs1_addr = 5'd5; wb_branch_hazard = 1; #1;
    if (flush === 1'b1) flush_cycles++;
    if (stall_flg !== 1'b0) stall_seen++;
    tick();
    wb_branch_hazard = 0; #1;
    n_total++; if (state !== 2'd3) $display("FAIL flush_state got %0d exp 3", state); else n_pass++;
    n_total++; if (pending !== 32'h0 || inflight !== 3'd0) $display("FAIL flush_cleared got %0h/%0d exp 0/0", pending, inflight); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (flush === 1'b1) flush_cycles++;
      if (stall_flg !== 1'b0) stall_seen++;
      tick(); #1;
    end
    n_total++; if (flush_cycles !== 3) $display("FAIL flush_len got %0d exp 3", flush_cycles); else n_pass++;
    n_total++; if (stall_seen !== 0) $display("FAIL flush_stall got %0d exp 0", stall_seen); else n_pass++;
    n_total++; if (state !== 2'd0) $display("FAIL flush_back_run got %0d exp 0", state); else n_pass++;
    // the rs1=x5 reader issued on the first RUN cycle after the window
    n_total++; if (inflight !== 3'd1) $display("FAIL flush_no_issue got %0d exp 1", inflight); else n_pass++;
    clear_inputs(); wb_valid = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_ecall();
    id_valid = 1;
    tick(); tick();
    id_is_ecall = 1; #1;
    n_total++; if (inflight !== 3'd2) $display("FAIL ecall_setup got %0d exp 2", inflight); else n_pass++;
    n_total++; if (stall_flg !== 1'b1) $display("FAIL ecall_stall_run got %0b exp 1", stall_flg); else n_pass++;
    tick();
    wb_valid = 1; #1;
    n_total++; if (state !== 2'd1) $display("FAIL ecall_drain got %0d exp 1", state); else n_pass++;
    tick(); tick();
    wb_valid = 0; #1;
    n_total++; if (inflight !== 3'd0 || state !== 2'd1 || stall_flg !== 1'b1) $display("FAIL ecall_drain_exit got %0d/%0d/%0b exp 0/1/1", inflight, state, stall_flg); else n_pass++;
    tick(); #1;
    n_total++; if (state !== 2'd0 || stall_flg !== 1'b0) $display("FAIL ecall_issue got %0d/%0b exp 0/0", state, stall_flg); else n_pass++;
    tick();
    id_is_ecall = 0; #1;
    n_total++; if (state !== 2'd2 || inflight !== 3'd1) $display("FAIL ecall_serial got %0d/%0d exp 2/1", state, inflight); else n_pass++;
    n_total++; if (stall_flg !== 1'b1) $display("FAIL ecall_serial_stall got %0b exp 1", stall_flg); else n_pass++;
    tick();
    wb_valid = 1; wb_is_ecall = 1;
    tick();
    wb_valid = 0; wb_is_ecall = 0; id_valid = 0; #1;
    n_total++; if (state !== 2'd0 || inflight !== 3'd0) $display("FAIL ecall_done got %0d/%0d exp 0/0", state, inflight); else n_pass++;
  endtask

  task automatic test_saturation();
    id_valid = 1;
    for (int i = 0; i < 7; i++) tick();
    #1;
    n_total++; if (inflight !== 3'd7) $display("FAIL sat_max got %0d exp 7", inflight); else n_pass++;
    n_total++; if (stall_flg !== 1'b1) $display("FAIL sat_stall got %0b exp 1", stall_flg); else n_pass++;
    wb_valid = 1;
    tick(); #1;
    n_total++; if (inflight !== 3'd6) $display("FAIL sat_full_retire got %0d exp 6", inflight); else n_pass++;
    tick(); #1;
    n_total++; if (inflight !== 3'd6) $display("FAIL issue_retire_same got %0d exp 6", inflight); else n_pass++;
    id_valid = 0;
    for (int i = 0; i < 8; i++) tick();
    wb_valid = 0; #1;
    n_total++; if (inflight !== 3'd0) $display("FAIL sat_zero got %0d exp 0", inflight); else n_pass++;
  endtask

  task automatic test_async_reset();
    id_valid = 1; id_is_ecall = 1;
    tick();
    id_is_ecall = 0; #1;
    n_total++; if (state !== 2'd2) $display("FAIL areset_setup got %0d exp 2", state); else n_pass++;
    rst = 1'b1; #1;
    n_total++; if (state !== 2'd0 || pending !== 32'h0 || inflight !== 3'd0) $display("FAIL areset_state got %0d/%0h/%0d exp 0/0/0", state, pending, inflight); else n_pass++;
    n_total++; if (stall_flg !== 1'b0) $display("FAIL areset_stall got %0b exp 0", stall_flg); else n_pass++;
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_x0();
    test_mem_busy();
    test_flush();
    test_ecall();
    test_saturation();
    test_async_reset();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline sequencing controller that owns the decode stage's `stall_flg` and flush inputs.
- Tracks pending register writes with a scoreboard and counts in-flight instructions.
- Serialises ECALL and sequences the post-branch flush window.
- Sits between the decode stage, the memory stage and writeback; its outputs drive decode and fetch hold/flush.

Parameters:
- INFLIGHT_W, 3, width of the in-flight instruction counter (max 7 outstanding).
- FLUSH_LEN, 2, cycles `flush` stays asserted after a writeback branch redirect (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a real (non-NOP) instruction.
- id_rs1_addr  in  5  decode rs1 index.
- id_rs2_addr  in  5  decode rs2 index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_wb_addr  in  5  decode destination index.
- id_rf_wen  in  1  instruction writes rd.
- id_is_ecall  in  1  decode instruction is ECALL.
- mem_busy  in  1  memory stage cannot accept a new instruction.
- wb_valid  in  1  an instruction retires this cycle.
- wb_rf_wen  in  1  the retiring instruction writes rd.
- wb_addr  in  5  destination of the retiring instruction.
- wb_is_ecall  in  1  the retiring instruction is ECALL.
- wb_branch_hazard  in  1  writeback redirects the PC.
- stall_flg  out  1  decode holds its saved instruction.
- flush  out  1  decode/fetch replace their contents with NOP.
- pending  out  32  scoreboard, bit r = write to xr outstanding; bit 0 is always 0.
- inflight  out  INFLIGHT_W  number of issued, unretired instructions.
- state  out  2  RUN=0, DRAIN=1, SERIAL=2, FLUSH=3.

Behaviour:

Reset:
- `pending`=0, `inflight`=0, `state`=RUN, flush counter=0.
- `stall_flg`=0, `flush`=0 combinationally while `rst` is high.
- Reset mid-operation discards all scoreboard and counter state immediately.

Hazard terms (combinational, from registered state only; no same-cycle writeback bypass):
- raw = (id_rs1_used & `pending`[rs1]) | (id_rs2_used & `pending`[rs2]).
- waw = id_rf_wen & id_wb_addr≠0 & `pending`[id_wb_addr].

Stall and issue:
- `stall_flg` = id_valid & (raw | waw | mem_busy | state≠RUN | (id_is_ecall & `inflight`≠0)).
- `stall_flg` is forced to 0 whenever `flush`=1.
- issue = id_valid & ~`stall_flg` & ~`flush`.

Scoreboard update (next cycle):
- Set `pending`[id_wb_addr] on issue if id_rf_wen and id_wb_addr≠0.
- Clear `pending`[wb_addr] on wb_valid & wb_rf_wen & wb_addr≠0.
- Set and clear on the same index in one cycle cannot occur: waw stalls it. Set wins if it ever does.
- A retired register is released one cycle after its writeback, because decode reads the regfile at the same edge as the write.

In-flight counter:
- `inflight` += issue, −= wb_valid; simultaneous issue and retire leaves it unchanged.
- `inflight` saturates at 0 and at its maximum. Reaching the maximum forces `stall_flg`.

Flush sequencing:
- wb_branch_hazard: `flush`=1 in that same cycle (combinational).
- Next cycle: `state`→FLUSH, `pending`←0, `inflight`←0, counter←FLUSH_LEN−1.
- In FLUSH: `flush`=1 and no issue. Counter decrements each cycle; at 0 → RUN.
- wb_branch_hazard has priority over every other event in every state. A new hazard while in FLUSH reloads the counter.

ECALL serialisation:
- RUN + id_valid & id_is_ecall & `inflight`≠0 → DRAIN, stalling.
- DRAIN → when `inflight`=0 and `pending`=0, go to RUN with no issue that cycle; the ECALL issues on the following RUN cycle.
- ECALL issue → SERIAL. SERIAL stalls everything until wb_valid & wb_is_ecall, then → RUN.
- RUN with `inflight`=0: the ECALL issues directly and goes to SERIAL.

Latency:
- `stall_flg` and `flush` are combinational in the current cycle.
- `pending`, `inflight` and `state` reflect an event on the next posedge.

Test Plan:
- RAW: issue `addi x5` (rf_wen, wb_addr=5), next cycle id rs1=5 used → `stall_flg`=1 until the cycle after wb_valid with wb_addr=5; `pending`[5] goes 0→1→0, then issue.
- x0 handling: issue with wb_addr=0, rf_wen=1 → `pending` stays 0x00000000, no stall on a dependent rs1=0.
- Flush: `pending`=0x00000060, `inflight`=2, wb_branch_hazard pulse → `flush`=1 for 1+FLUSH_LEN cycles total (3), `pending`=0, `inflight`=0, state FLUSH→RUN, `stall_flg`=0 throughout.
- ECALL: `inflight`=2, id_is_ecall → DRAIN with stall until two retires, then issue, SERIAL, stall until wb_is_ecall, then RUN.
- mem_busy held 3 cycles with no hazards → `stall_flg`=1 for exactly 3 cycles, scoreboard unchanged.
- Async reset asserted mid-SERIAL between clock edges → `state`=RUN, `pending`=0, `inflight`=0, `stall_flg`=0 immediately.
